// File: rtl/dmem_line_responder.sv
// Off-chip data memory model: answers L1 D-cache line requests
// after a fixed latency with a one-cycle ack pulse.
module dmem_line_responder #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam bit LAT1 = (LATENCY == 1);
  localparam logic [7:0] LAST = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t state;
  logic [7:0] cnt;
  logic wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0] idx_in;
  logic unused_addr;
  logic accept;
  logic finish;
  logic mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [DATA_W-1:0] mem_wdata;

  assign idx_in = addr_i[5 +: IDX_W];
  assign unused_addr = ^{addr_i[4:0],
                         addr_i[ADDR_W-1:5+IDX_W]};

  assign accept = (state == S_IDLE) && req_i;
  assign finish = (state == S_WAIT) && (cnt == LAST);

  // A 1-cycle build commits a write at the accept edge itself.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = idx_q;
    mem_wdata = wdata_q;
    if (rst_i) begin
      if (LAT1 && accept && write_i) begin
        mem_we    = 1'b1;
        mem_widx  = idx_in;
        mem_wdata = data_i;
      end else if (finish && wr_q) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= S_IDLE;
      cnt    <= 8'd0;
      ack_o  <= 1'b0;
      busy_o <= 1'b0;
      data_o <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_i) begin
            wr_q    <= write_i;
            idx_q   <= idx_in;
            wdata_q <= data_i;
            cnt     <= 8'd1;
            busy_o  <= 1'b1;
            if (LAT1) begin
              state <= S_ACK;
              ack_o <= 1'b1;
              if (!write_i) begin
                data_o <= mem[idx_in];
              end
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt + 8'd1;
          if (cnt == LAST) begin
            state <= S_ACK;
            ack_o <= 1'b1;
            if (!wr_q) begin
              data_o <= mem[idx_q];
            end
          end
        end
        S_ACK: begin
          state  <= S_IDLE;
          ack_o  <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Randomized bench for dmem_line_responder: a slow (LATENCY=10)
// and a fast (LATENCY=1) instance against a line-array model.
module tb_dmem_line_responder;

  int lat [2] = '{10, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic req [2];
  logic wr [2];
  logic [31:0] addr [2];
  logic [255:0] din [2];
  logic [255:0] dout [2];
  logic ack [2];
  logic busy [2];

  dmem_line_responder #(
    .DATA_W(256), .ADDR_W(32),
    .DEPTH(512), .LATENCY(10)
  ) u_slow (
    .clk_i(clk), .rst_i(rst),
    .req_i(req[0]), .write_i(wr[0]),
    .addr_i(addr[0]), .data_i(din[0]),
    .data_o(dout[0]), .ack_o(ack[0]),
    .busy_o(busy[0])
  );

  dmem_line_responder #(
    .DATA_W(256), .ADDR_W(32),
    .DEPTH(512), .LATENCY(1)
  ) u_fast (
    .clk_i(clk), .rst_i(rst),
    .req_i(req[1]), .write_i(wr[1]),
    .addr_i(addr[1]), .data_i(din[1]),
    .data_o(dout[1]), .ack_o(ack[1]),
    .busy_o(busy[1])
  );

  int total = 0;
  int bad = 0;

  logic [255:0] mdl [2][512];
  bit vld [2][512];
  logic [255:0] last_rd [2];

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] mk_addr(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[13:5] = 9'(idx);
    return a;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One request from idle; ack expected on the lat-th edge
  // counting the accept edge as the first.
  task automatic xact(input int d, input bit w,
                      input logic [31:0] a,
                      input logic [255:0] dat,
                      input bit jitter);
    int i9;
    int n;
    bit seen;
    i9 = int'(a[13:5]);
    req[d] = 1'b1;
    wr[d] = w;
    addr[d] = a;
    din[d] = dat;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      cyc();
      n++;
      if (ack[d]) begin
        seen = 1'b1;
      end else begin
        chk("busy_wait", 256'(busy[d]), 256'd1);
        if (jitter) begin
          req[d] = 1'($urandom);
          wr[d] = 1'($urandom);
          addr[d] = $urandom;
          din[d] = rnd_line();
        end
      end
    end
    chk("ack_seen", 256'(seen), 256'd1);
    req[d] = 1'b0;
    if (seen) begin
      chk("latency", 256'(n), 256'(lat[d]));
      chk("busy_ack", 256'(busy[d]), 256'd1);
      if (w) begin
        mdl[d][i9] = dat;
        vld[d][i9] = 1'b1;
        chk("dout_hold", dout[d], last_rd[d]);
      end else if (vld[d][i9]) begin
        chk("rdata", dout[d], mdl[d][i9]);
        last_rd[d] = mdl[d][i9];
      end
      addr[d] = $urandom;
      din[d] = rnd_line();
      cyc();
      chk("ack_width", 256'(ack[d]), 256'd0);
      chk("busy_idle", 256'(busy[d]), 256'd0);
    end
  endtask

  // req_i held high: accepts every lat+1 edges.
  task automatic b2b(input int d, input int idx);
    int l;
    int last_e;
    bit ea;
    bit eb;
    l = lat[d];
    last_e = 3 * (l + 1) + l;
    req[d] = 1'b1;
    wr[d] = 1'b0;
    addr[d] = mk_addr(idx);
    for (int e = 1; e <= last_e; e++) begin
      cyc();
      ea = ((e % (l + 1)) == l);
      eb = ((e % (l + 1)) != 0);
      chk("b2b_ack", 256'(ack[d]), 256'(ea));
      chk("b2b_busy", 256'(busy[d]), 256'(eb));
      if (ea) chk("b2b_rdata", dout[d], mdl[d][idx]);
    end
    req[d] = 1'b0;
    last_rd[d] = mdl[d][idx];
    cyc();
    chk("b2b_end_busy", 256'(busy[d]), 256'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [255:0] old5;
    logic [255:0] beef;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0;
      wr[d] = 1'b0;
      addr[d] = '0;
      din[d] = '0;
      last_rd[d] = '0;
      for (int i = 0; i < 512; i++) vld[d][i] = 1'b0;
    end
    cyc();
    cyc();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", 256'(ack[d]), 256'd0);
      chk("rst_busy", 256'(busy[d]), 256'd0);
      chk("rst_dout", dout[d], 256'd0);
    end
    rst = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        xact(d, 1'b1, mk_addr(i), rnd_line(), 1'b0);

    beef = {8{32'hDEADBEEF}};
    for (int d = 0; d < 2; d++) begin
      xact(d, 1'b1, 32'h0000_0040, beef, 1'b0);
      xact(d, 1'b0, 32'h0000_0040, rnd_line(), 1'b0);
      chk("beef_40", dout[d], beef);
      xact(d, 1'b0, 32'h0000_005F, rnd_line(), 1'b0);
      chk("beef_5f", dout[d], beef);
      xact(d, 1'b0, 32'h0000_4040, rnd_line(), 1'b0);
      chk("beef_alias", dout[d], beef);
    end

    for (int d = 0; d < 2; d++) begin
      xact(d, 1'b1, mk_addr(7), rnd_line(), 1'b1);
      xact(d, 1'b0, mk_addr(7), rnd_line(), 1'b1);
    end

    // Reset during WAIT discards the pending write.
    old5 = mdl[0][5];
    req[0] = 1'b1;
    wr[0] = 1'b1;
    addr[0] = mk_addr(5);
    din[0] = ~old5;
    cyc();
    cyc();
    rst = 1'b0;
    req[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("rst_mid_ack", 256'(ack[0]), 256'd0);
    end
    for (int d = 0; d < 2; d++) begin
      chk("rst_mid_busy", 256'(busy[d]), 256'd0);
      chk("rst_mid_dout", dout[d], 256'd0);
      last_rd[d] = '0;
    end
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk("rst_no_ack", 256'(ack[0]), 256'd0);
    end
    xact(0, 1'b0, mk_addr(5), rnd_line(), 1'b0);
    chk("rst_lost_wr", dout[0], old5);

    b2b(0, 3);
    b2b(1, 3);

    for (int k = 0; k < 60; k++) begin
      int d;
      int i;
      bit w;
      d = $urandom_range(0, 1);
      i = $urandom_range(0, 15);
      w = 1'($urandom_range(0, 1));
      xact(d, w, mk_addr(i), rnd_line(),
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
